// File: rtl/keycode_event_sequencer.sv
// Turns the CPU-written 24-bit keycode word into a queue of press/release/repeat
// events, with an Avalon-MM slave for control, timing and status.
module keycode_event_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TICK_DIV   = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] keycode_in,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        evt_valid,
    output logic        evt_press,
    output logic        evt_repeat,
    output logic [7:0]  evt_code,
    input  logic        evt_ready,
    output logic        irq
);

    localparam int PTR_W  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [23:0]       prev_q, prev_d;
    logic [23:0]       cur_q, cur_d;
    logic [2:0]        idx_q, idx_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [15:0]       delay_q, delay_d;
    logic [15:0]       rate_q, rate_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        rep_code_q, rep_code_d;
    logic [15:0]       rep_cnt_q, rep_cnt_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [9:0]        fifo_mem [FIFO_DEPTH];

    logic        wr_en;
    logic        is_rel_phase;
    logic [1:0]  sel;
    logic [7:0]  cand_code;
    logic        dup;
    logic        cand_hit;
    logic        push;
    logic [9:0]  push_data;
    logic        scan_press;
    logic        scan_release;
    logic        rep_fire;
    logic        rep_active;
    logic [2:0]  rep_match;
    logic        tick;
    logic [15:0] delay_eff;
    logic [15:0] rate_eff;
    logic        full;
    logic        do_pop;
    logic        do_push;
    logic [9:0]  head;

    function automatic logic [7:0] slot_of(input logic [23:0] w, input logic [1:0] k);
        logic [7:0] s;
        case (k)
            2'd0:    s = w[7:0];
            2'd1:    s = w[15:8];
            default: s = w[23:16];
        endcase
        return s;
    endfunction

    function automatic logic in_word(input logic [23:0] w, input logic [7:0] c);
        return (w[7:0] == c) || (w[15:8] == c) || (w[23:16] == c);
    endfunction

    assign wr_en = chipselect & ~write_n;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rep_match
            assign rep_match[gi] = (prev_q[8*gi +: 8] == rep_code_q);
        end
    endgenerate

    // Repeat only counts while its key is still part of the committed snapshot.
    assign rep_active = ctrl_q[1] && (rep_code_q != 8'h00) && (|rep_match);
    assign tick       = (tick_cnt_q == TICK_LAST);
    assign delay_eff  = (delay_q == 16'd0) ? 16'd1 : delay_q;
    assign rate_eff   = (rate_q == 16'd0) ? 16'd1 : rate_q;

    // One candidate slot per SCAN cycle: idx 0-2 look at old slots, 3-5 at new slots.
    always_comb begin
        is_rel_phase = (idx_q < 3'd3);
        sel          = is_rel_phase ? idx_q[1:0] : 2'(idx_q - 3'd3);
        cand_code    = is_rel_phase ? slot_of(prev_q, sel) : slot_of(cur_q, sel);
        case (sel)
            2'd1:    dup = (cur_q[7:0] == cand_code);
            2'd2:    dup = (cur_q[7:0] == cand_code) || (cur_q[15:8] == cand_code);
            default: dup = 1'b0;
        endcase
        if (is_rel_phase) begin
            cand_hit = (cand_code != 8'h00) && !in_word(cur_q, cand_code);
        end else begin
            cand_hit = (cand_code != 8'h00) && !in_word(prev_q, cand_code) && !dup;
        end
    end

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        cur_d        = cur_q;
        idx_d        = idx_q;
        push         = 1'b0;
        push_data    = 10'h000;
        scan_press   = 1'b0;
        scan_release = 1'b0;
        rep_fire     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[0] && (keycode_in != prev_q)) begin
                    cur_d   = keycode_in;
                    idx_d   = 3'd0;
                    state_d = ST_SCAN;
                end else if (ctrl_q[0] && rep_active && (rep_cnt_q == 16'd0)) begin
                    rep_fire  = 1'b1;
                    push      = 1'b1;
                    push_data = {1'b1, 1'b1, rep_code_q};
                end
            end
            ST_SCAN: begin
                if (cand_hit) begin
                    push         = 1'b1;
                    push_data    = {~is_rel_phase, 1'b0, cand_code};
                    scan_press   = ~is_rel_phase;
                    scan_release = is_rel_phase;
                end
                if (idx_q == 3'd5) begin
                    prev_d  = cur_q;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        rep_code_d = rep_code_q;
        rep_cnt_d  = rep_cnt_q;
        if (scan_press) begin
            rep_code_d = cand_code;
        end else if (scan_release && (cand_code == rep_code_q)) begin
            rep_code_d = 8'h00;
        end
        if (scan_press) begin
            rep_cnt_d = delay_eff;
        end else if (rep_fire) begin
            rep_cnt_d = rate_eff;
        end else if (tick && rep_active && (rep_cnt_q != 16'd0)) begin
            rep_cnt_d = rep_cnt_q - 16'd1;
        end
    end

    // A pop frees the slot in the same cycle, so a full queue still accepts a push then.
    always_comb begin
        full       = (count_q == DEPTH_C);
        do_pop     = evt_valid & evt_ready;
        do_push    = push & (~full | do_pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(do_pop);
        count_d    = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        overflow_d = overflow_q;
        if (wr_en && (address == 2'd2) && writedata[1]) begin
            overflow_d = 1'b0;
        end
        if (push && full && !do_pop) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        delay_d = delay_q;
        rate_d  = rate_q;
        if (wr_en) begin
            case (address)
                2'd0: ctrl_d = writedata[2:0];
                2'd1: begin
                    delay_d = writedata[15:0];
                    rate_d  = writedata[31:16];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            prev_q     <= 24'h000000;
            cur_q      <= 24'h000000;
            idx_q      <= 3'd0;
            ctrl_q     <= 3'd0;
            delay_q    <= 16'd500;
            rate_q     <= 16'd33;
            overflow_q <= 1'b0;
            rep_code_q <= 8'h00;
            rep_cnt_q  <= 16'd0;
            tick_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            cur_q      <= cur_d;
            idx_q      <= idx_d;
            ctrl_q     <= ctrl_d;
            delay_q    <= delay_d;
            rate_q     <= rate_d;
            overflow_q <= overflow_d;
            rep_code_q <= rep_code_d;
            rep_cnt_q  <= rep_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the count is zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr_q] <= push_data;
        end
    end

    assign head       = fifo_mem[rd_ptr_q];
    assign evt_valid  = (count_q != '0);
    assign evt_press  = evt_valid & head[9];
    assign evt_repeat = evt_valid & head[8];
    assign evt_code   = evt_valid ? head[7:0] : 8'h00;
    assign irq        = evt_valid & ctrl_q[2];

    always_comb begin
        readdata = 32'h0000_0000;
        case (address)
            2'd0: readdata = {29'd0, ctrl_q};
            2'd1: readdata = {rate_q, delay_q};
            2'd2: readdata = {23'd0, 5'(count_q), 2'b00, overflow_q, (state_q == ST_SCAN)};
            2'd3: readdata = {8'd0, prev_q};
            default: readdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_keycode_event_sequencer.sv
// Bench for keycode_event_sequencer: event-list reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_keycode_event_sequencer;

    localparam int DEPTH = 4;
    localparam int TDIV  = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] keycode_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        evt_valid;
    logic        evt_press;
    logic        evt_repeat;
    logic [7:0]  evt_code;
    logic        evt_ready;
    logic        irq;

    always #5 clk = ~clk;

    keycode_event_sequencer #(
        .FIFO_DEPTH(DEPTH),
        .TICK_DIV  (TDIV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .keycode_in (keycode_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .evt_valid  (evt_valid),
        .evt_press  (evt_press),
        .evt_repeat (evt_repeat),
        .evt_code   (evt_code),
        .evt_ready  (evt_ready),
        .irq        (irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    // staged inputs, applied at the next falling edge
    logic        s_rstn;
    logic [23:0] s_kin;
    logic [1:0]  s_addr;
    logic        s_cs;
    logic        s_wn;
    logic [31:0] s_wd;
    logic        s_rdy;

    // reference model state
    logic [23:0] m_prev;
    logic [23:0] m_cur;
    int          m_left;
    logic [9:0]  m_sched [6];
    bit          m_sv [6];
    logic [2:0]  m_ctrl;
    logic [15:0] m_delay;
    logic [15:0] m_rate;
    bit          m_ovf;
    logic [9:0]  m_q [$];
    logic [7:0]  m_rep_code;
    int          m_rep_cnt;
    int          m_cyc;

    logic [9:0]  dut_log [$];
    int          dut_t [$];
    int          cyc_no = 0;
    logic [31:0] last_rd;
    bit          irq_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit has(input logic [23:0] w, input logic [7:0] c);
        return (c != 8'h00) && ((w[7:0] == c) || (w[15:8] == c) || (w[23:16] == c));
    endfunction

    task automatic model_reset();
        m_prev = '0; m_cur = '0; m_left = 0;
        m_ctrl = '0; m_delay = 16'd500; m_rate = 16'd33; m_ovf = 0;
        m_q.delete(); m_rep_code = '0; m_rep_cnt = 0; m_cyc = 0;
        for (int i = 0; i < 6; i++) begin m_sv[i] = 0; m_sched[i] = '0; end
    endtask

    // Releases of old slots in slot order, then first appearances of new codes.
    task automatic plan_scan(input logic [23:0] w);
        logic [7:0] c;
        bit seen;
        m_cur  = w;
        m_left = 6;
        for (int i = 0; i < 3; i++) begin
            c = m_prev[8*i +: 8];
            m_sv[i]    = (c != 8'h00) && !has(w, c);
            m_sched[i] = {2'b00, c};
        end
        for (int i = 0; i < 3; i++) begin
            c = w[8*i +: 8];
            seen = 0;
            for (int j = 0; j < i; j++) if (w[8*j +: 8] == c) seen = 1;
            m_sv[3+i]    = (c != 8'h00) && !has(m_prev, c) && !seen;
            m_sched[3+i] = {2'b10, c};
        end
    endtask

    task automatic model_next();
        bit pop, tick, active, fire, pressed, push;
        logic [9:0] ev;
        logic [7:0] new_code;
        int k, new_cnt, de, re;
        pop    = (m_q.size() > 0) && s_rdy;
        tick   = (m_cyc % TDIV) == (TDIV - 1);
        m_cyc++;
        active = m_ctrl[1] && has(m_prev, m_rep_code);
        de     = (m_delay == 16'd0) ? 1 : int'(m_delay);
        re     = (m_rate == 16'd0) ? 1 : int'(m_rate);
        push = 0; fire = 0; pressed = 0; ev = '0;
        new_code = m_rep_code;
        new_cnt  = m_rep_cnt;
        if (m_left > 0) begin
            k = 6 - m_left;
            if (m_sv[k]) begin
                push = 1;
                ev   = m_sched[k];
                if (ev[9]) begin
                    pressed  = 1;
                    new_code = ev[7:0];
                    new_cnt  = de;
                end else if (ev[7:0] == m_rep_code) begin
                    new_code = 8'h00;
                end
            end
            m_left--;
            if (m_left == 0) m_prev = m_cur;
        end else if (m_ctrl[0] && (s_kin != m_prev)) begin
            plan_scan(s_kin);
        end else if (m_ctrl[0] && active && (m_rep_cnt == 0)) begin
            fire    = 1;
            push    = 1;
            ev      = {2'b11, m_rep_code};
            new_cnt = re;
        end
        if (!pressed && !fire && tick && active && (m_rep_cnt > 0)) new_cnt = m_rep_cnt - 1;
        m_rep_code = new_code;
        m_rep_cnt  = new_cnt;
        if (pop) void'(m_q.pop_front());
        if (s_cs && !s_wn && (s_addr == 2'd2) && s_wd[1]) m_ovf = 0;
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(ev);
            else m_ovf = 1;
        end
        if (s_cs && !s_wn) begin
            if (s_addr == 2'd0) m_ctrl = s_wd[2:0];
            if (s_addr == 2'd1) begin m_delay = s_wd[15:0]; m_rate = s_wd[31:16]; end
        end
    endtask

    task automatic compare();
        logic [9:0]  h;
        logic [31:0] exp_rd;
        logic [4:0]  cnt5;
        bit          v;
        v    = (m_q.size() > 0);
        h    = v ? m_q[0] : 10'h000;
        cnt5 = 5'(m_q.size());
        case (s_addr)
            2'd0:    exp_rd = {29'd0, m_ctrl};
            2'd1:    exp_rd = {m_rate, m_delay};
            2'd2:    exp_rd = {23'd0, cnt5, 2'b00, m_ovf, (m_left > 0)};
            default: exp_rd = {8'd0, m_prev};
        endcase
        chk("evt_valid", 32'(evt_valid), 32'(v));
        chk("evt_press", 32'(evt_press), 32'(h[9]));
        chk("evt_repeat", 32'(evt_repeat), 32'(h[8]));
        chk("evt_code", 32'(evt_code), 32'(h[7:0]));
        chk("irq", 32'(irq), 32'(v && m_ctrl[2]));
        chk("readdata", readdata, exp_rd);
    endtask

    task automatic step();
        @(negedge clk);
        reset_n = s_rstn; keycode_in = s_kin; address = s_addr;
        chipselect = s_cs; write_n = s_wn; writedata = s_wd; evt_ready = s_rdy;
        #1;
        last_rd = readdata;
        if (!reset_n) begin
            model_reset();
        end else begin
            compare();
            if (irq) irq_seen = 1;
            if (evt_valid && evt_ready) begin
                dut_log.push_back({evt_press, evt_repeat, evt_code});
                dut_t.push_back(cyc_no);
            end
            model_next();
        end
        cyc_no++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        s_cs = 1; s_wn = 0; s_addr = a; s_wd = d;
        step();
        s_cs = 0; s_wn = 1;
    endtask

    task automatic rd(input logic [1:0] a);
        s_addr = a;
        step();
    endtask

    task automatic clear_log();
        dut_log.delete();
        dut_t.delete();
    endtask

    function automatic logic [7:0] rcode();
        return 8'($urandom_range(0, 4));
    endfunction

    initial begin
        int busy_cycles;
        s_rstn = 0; s_kin = '0; s_addr = '0; s_cs = 0; s_wn = 1; s_wd = '0; s_rdy = 1;
        reset_n = 0; keycode_in = '0; address = '0; chipselect = 0; write_n = 1;
        writedata = '0; evt_ready = 1;
        model_reset();
        run(3);
        s_rstn = 1;

        // reset values
        rd(2'd0); chk("reset_ctrl", last_rd, 32'h0000_0000);
        rd(2'd1); chk("reset_timing", last_rd, 32'h0021_01F4);
        rd(2'd2); chk("reset_status", last_rd, 32'h0000_0000);
        rd(2'd3); chk("reset_snap", last_rd, 32'h0000_0000);
        chk("reset_evt_valid", 32'(evt_valid), 32'd0);

        // single press
        wr(2'd0, 32'h5);
        irq_seen = 0; clear_log();
        s_kin = 24'h000004; s_rdy = 1;
        run(12);
        chk("press_count", 32'(dut_log.size()), 32'd1);
        if (dut_log.size() > 0) chk("press_event", 32'(dut_log[0]), 32'h204);
        rd(2'd3); chk("press_snap", last_rd, 32'h0000_0004);
        chk("press_irq_seen", 32'(irq_seen), 32'd1);

        // multi-change in one step
        s_kin = 24'h001604; run(12);
        clear_log();
        s_kin = 24'h1A0700; s_addr = 2'd2; busy_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (last_rd[0]) busy_cycles++;
        end
        chk("multi_busy_cycles", 32'(busy_cycles), 32'd6);
        chk("multi_count", 32'(dut_log.size()), 32'd4);
        if (dut_log.size() == 4) begin
            chk("multi_ev0", 32'(dut_log[0]), 32'h004);
            chk("multi_ev1", 32'(dut_log[1]), 32'h016);
            chk("multi_ev2", 32'(dut_log[2]), 32'h207);
            chk("multi_ev3", 32'(dut_log[3]), 32'h21A);
        end

        // duplicates and empty slots
        s_kin = 24'h000000; run(12); clear_log();
        s_kin = 24'h040004; run(12);
        chk("dup_count", 32'(dut_log.size()), 32'd1);
        if (dut_log.size() > 0) chk("dup_event", 32'(dut_log[0]), 32'h204);
        clear_log();
        s_kin = 24'h000004; run(12);
        chk("dup_noevents", 32'(dut_log.size()), 32'd0);

        // overflow
        s_kin = 24'h000000; run(12); clear_log();
        s_rdy = 0;
        s_kin = 24'h0A0908; run(10);
        s_kin = 24'h000000; run(10);
        rd(2'd2); chk("ovf_status", last_rd, 32'h0000_0042);
        wr(2'd2, 32'h2);
        rd(2'd2); chk("ovf_cleared", last_rd, 32'h0000_0040);
        s_rdy = 1; run(10);
        chk("ovf_count", 32'(dut_log.size()), 32'd4);
        if (dut_log.size() == 4) begin
            chk("ovf_ev0", 32'(dut_log[0]), 32'h208);
            chk("ovf_ev1", 32'(dut_log[1]), 32'h209);
            chk("ovf_ev2", 32'(dut_log[2]), 32'h20A);
            chk("ovf_ev3", 32'(dut_log[3]), 32'h008);
        end

        // auto-repeat: DELAY=3, RATE=2 ticks of 4 cycles
        wr(2'd1, 32'h0002_0003);
        wr(2'd0, 32'h7);
        clear_log();
        s_kin = 24'h00002C; run(50);
        chk("rep_min_events", 32'(dut_log.size() >= 4), 32'd1);
        if (dut_log.size() > 0) chk("rep_press", 32'(dut_log[0]), 32'h22C);
        for (int i = 1; i < dut_log.size(); i++) begin
            chk("rep_event", 32'(dut_log[i]), 32'h32C);
            if (i == 1) chk("rep_first_gap", 32'((dut_t[1] - dut_t[0]) >= 8 && (dut_t[1] - dut_t[0]) <= 16), 32'd1);
            else chk("rep_gap", 32'(dut_t[i] - dut_t[i-1]), 32'd8);
        end
        clear_log();
        s_kin = 24'h000000; run(40);
        chk("rep_release_count", 32'(dut_log.size()), 32'd1);
        if (dut_log.size() > 0) chk("rep_release_event", 32'(dut_log[0]), 32'h02C);

        // reset in the middle of a six-event scan
        wr(2'd0, 32'h1);
        s_kin = 24'h030201; run(12); clear_log();
        s_kin = 24'h060504;
        run(3);
        s_rstn = 0; rd(2'd3);
        chk("rst_evt_valid", 32'(evt_valid), 32'd0);
        chk("rst_snap", last_rd, 32'h0000_0000);
        rd(2'd0);
        chk("rst_ctrl", last_rd, 32'h0000_0000);
        s_rstn = 1;
        step();
        clear_log();
        run(20);
        chk("rst_no_events", 32'(dut_log.size()), 32'd0);
        rd(2'd3); chk("rst_snap_held", last_rd, 32'h0000_0000);

        // randomized traffic against the model
        wr(2'd0, 32'h7);
        wr(2'd1, {14'd0, 2'($urandom_range(0, 2)), 14'd0, 2'($urandom_range(0, 3))});
        for (int i = 0; i < 2000; i++) begin
            s_rdy = (i < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) s_kin = {rcode(), rcode(), rcode()};
            s_addr = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) begin
                s_cs = 1; s_wn = 0; s_addr = 2'd2; s_wd = 32'h2;
            end else if ($urandom_range(0, 149) == 0) begin
                s_cs = 1; s_wn = 0; s_addr = 2'd1;
                s_wd = {14'd0, 2'($urandom_range(0, 2)), 14'd0, 2'($urandom_range(0, 3))};
            end else begin
                s_cs = 0; s_wn = 1;
            end
            step();
        end
        s_cs = 0; s_wn = 1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/keycode_event_sequencer.md
Name: keycode_event_sequencer

Overview:
- Converts the 24-bit packed keycode word into discrete press/release events for game logic. The word holds three 8-bit slots written by the CPU over the PIO.
- Diffs successive snapshots, generates optional auto-repeat for the newest held key, and queues events in a small FIFO drained by a valid/ready handshake.
- Has an Avalon-MM slave for configuration and status. Sits between the keycode PIO out_port and the game controller FSM.

Parameters:
FIFO_DEPTH, 4, event queue entries (power of 2, 2..16)
TICK_DIV, 50000, clk cycles per repeat tick (1 ms at 50 MHz)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
keycode_in  input  24  packed keycodes; slot k = bits [8k+7:8k]; 0x00 = empty
address  input  2  Avalon register select
chipselect  input  1  Avalon select
write_n  input  1  Avalon write strobe, active low
writedata  input  32  Avalon write data
readdata  output  32  Avalon read data, combinational from address
evt_valid  output  1  FIFO head valid
evt_press  output  1  1 = press/repeat, 0 = release
evt_repeat  output  1  1 = auto-repeat event
evt_code  output  8  keycode of event
evt_ready  input  1  consumer accepts head when evt_valid & evt_ready
irq  output  1  level: FIFO non-empty & CTRL.irq_en

Behaviour:
- Reset:
  - prev snapshot = 0; FIFO empty; FSM in IDLE.
  - CTRL = 0; DELAY = 500; RATE = 33; overflow = 0.
  - All outputs 0.
- Registers:
  - 0 CTRL: bit0 enable, bit1 repeat_en, bit2 irq_en. Read/write.
  - 1 TIMING: [15:0] DELAY ticks, [31:16] RATE ticks. Read/write. A value of 0 is treated as 1.
  - 2 STATUS (read): [0] busy (FSM not IDLE), [1] overflow, [8:4] FIFO count. Writing 1 to bit1 clears overflow.
  - 3 SNAP (read): [23:0] prev snapshot. Writes ignored.
- FSM:
  - IDLE:
    - If enable and keycode_in != prev: latch keycode_in into cur, set idx=0, go to SCAN.
    - Else, if a repeat fires: push one event, stay in IDLE.
  - SCAN: one candidate per cycle, idx 0..5.
    - idx 0-2 = release check on prev slot idx. Emit a release if the code is nonzero and absent from all three cur slots.
    - idx 3-5 = press check on cur slot idx-3. Emit a press if the code is nonzero, absent from all prev slots, and not equal to an earlier cur slot (duplicate suppression).
    - After idx 5: prev <= cur, go to IDLE.
    - Worst case 6 cycles; keycode_in changes during SCAN are picked up on the next IDLE cycle.
- Auto-repeat:
  - rep_code = code of the last press emitted; a new press retargets it.
  - On a press, rep_cnt = DELAY.
  - The tick prescaler runs freely. rep_cnt decrements on each tick while rep_code is present in prev and repeat_en = 1.
  - At 0, in IDLE only: push {press=1, repeat=1, rep_code}, reload rep_cnt = RATE.
  - If rep_code is released, repeat stops and rep_code = 0.
  - A repeat due while in SCAN waits until IDLE.
- FIFO:
  - Push and pop in the same cycle are both honoured, even when full.
  - Push while full and no pop: event dropped, overflow set (sticky).
  - evt_* outputs reflect the head; they hold stable while evt_valid & !evt_ready.
- enable = 0:
  - FSM finishes any SCAN in progress, then stays in IDLE.
  - No new events are generated; the FIFO still drains; prev is held.
- Reset mid-SCAN: everything returns to reset values immediately; no partial events remain.

Test Plan:
- Press one key: enable=1, keycode_in 0x000000 -> 0x000004 (A), evt_ready=1 -> exactly one event {press=1, repeat=0, code=0x04}; SNAP reads 0x000004; irq pulses while non-empty.
- Multi-change in one step: 0x001604 -> 0x1A0700 -> events in order: release 0x04, release 0x16, press 0x07, press 0x1A; STATUS.busy=1 for 6 cycles.
- Duplicate and empty slots: 0x000000 -> 0x040004 -> one press 0x04 only; then 0x040004 -> 0x000004 -> no events.
- Overflow: evt_ready=0, FIFO_DEPTH=4, 0x000000 -> 0x0A0908 then -> 0x000000 -> 4 events queued, the remaining release events dropped, overflow=1; write 0x2 to STATUS -> overflow=0.
- Auto-repeat: TICK_DIV=4, DELAY=3, RATE=2, repeat_en=1, hold 0x00002C -> first repeat 12 cycles after the press (±4 prescaler phase), then one every 8 cycles with repeat=1; release -> release event, no further repeats.
- Async reset mid-SCAN: assert reset_n=0 during cycle idx=2 of a 6-event scan -> evt_valid=0, SNAP=0, CTRL=0 immediately; after release with enable=0 and unchanged input, no events.
